mdu_rs: RTL



---
 rtl/mdu_rs.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mdu_rs.sv
// mdu_rs: reservation station feeding the MDU.
// Ops are held in a collapsing queue, so entry 0 is always the oldest and the
// valid entries are exactly indices [0, count). Operands wake from CDB
// broadcasts. The oldest op whose operands are both ready issues over a
// valid/ready handshake.

package mdu_rs_pkg;
    localparam int TAG_W = 6;

    typedef enum logic [2:0] {
        FNC_MUL, FNC_MULH, FNC_MULHSU, FNC_MULHU,
        FNC_DIV, FNC_DIVU, FNC_REM, FNC_REMU
    } mdu_fnc_t;

    typedef struct packed {
        logic [31:0]      data;
        logic             is_renamed;
        logic [TAG_W-1:0] tag;
    } operand_t;

    typedef struct packed {
        logic             is_valid;
        mdu_fnc_t         uop_0;
        operand_t         src_0_a;
        operand_t         src_0_b;
        logic [TAG_W-1:0] dest_tag;
        logic             has_rd;
    } instruction_t;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        logic [31:0]      result;
    } writeback_packet_t;
endpackage

module mdu_rs
    import mdu_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  instruction_t      rs_packet,
    output logic              rs_rdy,
    input  writeback_packet_t cdb_result,
    input  logic              mdu_rdy,
    output instruction_t      mdu_packet
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    instruction_t entries [NUM_ENTRIES];
    instruction_t woken   [NUM_ENTRIES];
    instruction_t shifted [NUM_ENTRIES];
    instruction_t nxt     [NUM_ENTRIES];

    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_nxt;
    logic [CNT_W-1:0]       alloc_idx;
    logic [NUM_ENTRIES-1:0] cand;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_cand;
    logic                   alloc;
    logic                   fire;

    // A renamed operand whose producer tag is on a valid broadcast takes the result.
    function automatic operand_t wake_op(operand_t op, writeback_packet_t cdb);
        operand_t r;
        r = op;
        if (op.is_renamed && cdb.is_valid && (op.tag == cdb.dest_tag)) begin
            r.data       = cdb.result;
            r.is_renamed = 1'b0;
        end
        return r;
    endfunction

    // Readiness comes from registered count only, so an issue in this cycle does not open a slot.
    assign rs_rdy = (count < CNT_W'(NUM_ENTRIES));

    // Oldest-ready select over registered state. The lowest index wins because entry 0 is the oldest.
    always_comb begin
        cand     = '0;
        win_idx  = '0;
        any_cand = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            cand[i] = (CNT_W'(i) < count) &&
                      !entries[i].src_0_a.is_renamed && !entries[i].src_0_b.is_renamed;
            if (cand[i]) win_idx = IDX_W'(i);
        end
        any_cand   = |cand;
        mdu_packet = '0;
        if (mdu_rdy && any_cand && !flush) begin
            mdu_packet          = entries[win_idx];
            mdu_packet.is_valid = 1'b1;
        end
    end

    assign fire = mdu_packet.is_valid;

    // Next-state queue: wake operands, collapse over the issued entry, then append the new op at the tail.
    always_comb begin
        alloc     = rs_packet.is_valid && rs_rdy && !flush;
        alloc_idx = count - CNT_W'(fire);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woken[i]         = entries[i];
            woken[i].src_0_a = wake_op(entries[i].src_0_a, cdb_result);
            woken[i].src_0_b = wake_op(entries[i].src_0_b, cdb_result);
        end
        for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            shifted[i] = woken[i+1];
        end
        shifted[NUM_ENTRIES-1] = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            nxt[i] = (fire && (CNT_W'(i) >= CNT_W'(win_idx))) ? shifted[i] : woken[i];
            if (alloc && (CNT_W'(i) == alloc_idx)) begin
                nxt[i]         = rs_packet;
                nxt[i].src_0_a = wake_op(rs_packet.src_0_a, cdb_result);
                nxt[i].src_0_b = wake_op(rs_packet.src_0_b, cdb_result);
            end
        end
        count_nxt = count + CNT_W'(alloc) - CNT_W'(fire);
        if (flush) begin
            count_nxt = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                nxt[i] = '0;
            end
        end
    end

    // Queue and occupancy registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            entries <= '{default: '0};
        end else begin
            count   <= count_nxt;
            entries <= nxt;
        end
    end
endmodule
